sbus_spi_sequencer: RTL and testbench

SBUS_SPI_SEQUENCER -- requirements
Module: sbus_spi_sequencer

---
 rtl/sbus_spi_pkg.sv | 34 +++
 rtl/sbus_spi_sequencer_if.sv | 14 +
 rtl/sbus_access.sv | 61 ++++++
 rtl/sbus_spi_sequencer.sv | 145 ++++++++++++++
 tb/tb_sbus_spi_sequencer.sv | 359 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sbus_spi_pkg.sv
// Shared register map, status bit positions and sequencer states for the
// SPI controller that sits behind the 8-bit system bus.
package sbus_spi_pkg;

    localparam logic [7:0] SPICR0  = 8'h08;
    localparam logic [7:0] SPICR1  = 8'h09;
    localparam logic [7:0] SPICR2  = 8'h0A;
    localparam logic [7:0] SPIBR   = 8'h0B;
    localparam logic [7:0] SPISR   = 8'h0C;
    localparam logic [7:0] SPITXDR = 8'h0D;
    localparam logic [7:0] SPIRXDR = 8'h0E;
    localparam logic [7:0] SPICSR  = 8'h0F;

    localparam int unsigned TRDY = 4;
    localparam int unsigned RRDY = 3;

    // SPICSR values: CS0 driven low, all chip selects released.
    localparam logic [7:0] CS_ASSERT  = 8'h0E;
    localparam logic [7:0] CS_RELEASE = 8'h0F;

    typedef enum logic [3:0] {
        CFG,
        IDLE,
        CS_ON,
        POLL_TX,
        WRITE_TX,
        POLL_RX,
        READ_RX,
        RESP,
        CS_OFF,
        ERROR
    } state_e;

endpackage

// File: rtl/sbus_spi_sequencer_if.sv
// System-bus port bundle: the sequencer is the master, the register file the slave.
interface sbus_spi_sequencer_if;
    logic       stb;
    logic       rw;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata;
    logic       ack;

    modport master (output stb, output rw, output addr, output wdata,
                    input rdata, input ack);
    modport slave  (input stb, input rw, input addr, input wdata,
                    output rdata, output ack);
endinterface

// File: rtl/sbus_access.sv
// Single system-bus access engine: raises the strobe on start, holds the request
// stable until ack, and abandons the access after ACK_TIMEOUT strobe-high cycles.
module sbus_access #(
    parameter int unsigned ACK_TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 rw,
    input  logic [7:0]           addr,
    input  logic [7:0]           wdata,
    sbus_spi_sequencer_if.master sb,
    output logic                 busy,
    output logic                 ack_hit,
    output logic                 timeout_hit,
    output logic [7:0]           rdata
);

    localparam int unsigned CntW = $clog2(ACK_TIMEOUT + 1);

    logic            stb_q;
    logic            rw_q;
    logic [7:0]      addr_q;
    logic [7:0]      wdata_q;
    logic [CntW-1:0] cnt_q;

    // Ack and timeout are only meaningful while our own strobe is up, so a
    // stray ack after reset or after a timeout is ignored.
    assign ack_hit     = stb_q && sb.ack;
    assign timeout_hit = stb_q && !sb.ack && (cnt_q == CntW'(ACK_TIMEOUT - 1));
    assign rdata       = sb.rdata;
    assign busy        = stb_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stb_q   <= 1'b0;
            rw_q    <= 1'b0;
            addr_q  <= 8'h00;
            wdata_q <= 8'h00;
            cnt_q   <= '0;
        end else if (stb_q) begin
            if (ack_hit || timeout_hit) begin
                stb_q <= 1'b0;
            end else begin
                cnt_q <= cnt_q + CntW'(1);
            end
        end else if (start) begin
            stb_q   <= 1'b1;
            rw_q    <= rw;
            addr_q  <= addr;
            wdata_q <= wdata;
            cnt_q   <= '0;
        end
    end

    assign sb.stb   = stb_q;
    assign sb.rw    = rw_q;
    assign sb.addr  = addr_q;
    assign sb.wdata = wdata_q;

endmodule

// File: rtl/sbus_spi_sequencer.sv
// Drives an SPI master register block over the system bus: configures it after
// reset, then runs one chip-select-framed byte exchange per accepted request.
module sbus_spi_sequencer
    import sbus_spi_pkg::*;
#(
    parameter logic [7:0]  CLK_DIV     = 8'd5,
    parameter logic [1:0]  SPI_MODE    = 2'b00,
    parameter int unsigned ACK_TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [7:0]           req_data,
    input  logic                 req_last,
    output logic                 rsp_valid,
    output logic [7:0]           rsp_data,
    output logic                 error,
    sbus_spi_sequencer_if.master sb
);

    state_e     state_q, state_d;
    logic [1:0] cfg_idx_q;
    logic [7:0] data_q;
    logic       last_q;
    logic       cs_on_q;
    logic       error_q;
    logic       req_ready_q;
    logic       rsp_valid_q;
    logic [7:0] rsp_data_q;

    logic       acc_req;
    logic       acc_start;
    logic       acc_rw;
    logic [7:0] acc_addr;
    logic [7:0] acc_wdata;
    logic       acc_busy;
    logic       ack_hit;
    logic       timeout_hit;
    logic [7:0] acc_rdata;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= CFG;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            CFG:      if (ack_hit && cfg_idx_q == 2'd3) state_d = IDLE;
            IDLE:     if (req_valid && req_ready_q) state_d = cs_on_q ? POLL_TX : CS_ON;
            CS_ON:    if (ack_hit) state_d = POLL_TX;
            POLL_TX:  if (ack_hit && acc_rdata[TRDY]) state_d = WRITE_TX;
            WRITE_TX: if (ack_hit) state_d = POLL_RX;
            POLL_RX:  if (ack_hit && acc_rdata[RRDY]) state_d = READ_RX;
            READ_RX:  if (ack_hit) state_d = RESP;
            RESP:     state_d = last_q ? CS_OFF : IDLE;
            CS_OFF:   if (ack_hit) state_d = IDLE;
            ERROR:    state_d = ERROR;
            default:  state_d = ERROR;
        endcase
        if (timeout_hit) state_d = ERROR;
    end

    always_comb begin
        acc_req   = 1'b0;
        acc_rw    = 1'b0;
        acc_addr  = 8'h00;
        acc_wdata = 8'h00;
        unique case (state_q)
            CFG: begin
                acc_req = 1'b1;
                acc_rw  = 1'b1;
                unique case (cfg_idx_q)
                    2'd0: begin acc_addr = SPICR1; acc_wdata = 8'h80; end
                    2'd1: begin acc_addr = SPIBR;  acc_wdata = CLK_DIV; end
                    2'd2: begin acc_addr = SPICR2; acc_wdata = {2'b11, 3'b000, SPI_MODE, 1'b0}; end
                    2'd3: begin acc_addr = SPICSR; acc_wdata = CS_RELEASE; end
                    default: ;
                endcase
            end
            CS_ON:    begin acc_req = 1'b1; acc_rw = 1'b1; acc_addr = SPICSR; acc_wdata = CS_ASSERT; end
            POLL_TX:  begin acc_req = 1'b1; acc_addr = SPISR; end
            WRITE_TX: begin acc_req = 1'b1; acc_rw = 1'b1; acc_addr = SPITXDR; acc_wdata = data_q; end
            POLL_RX:  begin acc_req = 1'b1; acc_addr = SPISR; end
            READ_RX:  begin acc_req = 1'b1; acc_addr = SPIRXDR; end
            CS_OFF:   begin acc_req = 1'b1; acc_rw = 1'b1; acc_addr = SPICSR; acc_wdata = CS_RELEASE; end
            default: ;
        endcase
    end

    // A new access only starts once the previous strobe is down, which gives the
    // mandatory idle cycle between accesses and repeats polls automatically.
    assign acc_start = acc_req && !acc_busy;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cfg_idx_q   <= 2'd0;
            data_q      <= 8'h00;
            last_q      <= 1'b0;
            cs_on_q     <= 1'b0;
            error_q     <= 1'b0;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 8'h00;
        end else begin
            req_ready_q <= (state_d == IDLE);
            rsp_valid_q <= (state_d == RESP);
            if (state_q == CFG && ack_hit) cfg_idx_q <= cfg_idx_q + 2'd1;
            if (state_q == IDLE && req_valid && req_ready_q) begin
                data_q <= req_data;
                last_q <= req_last;
            end
            if (state_q == CS_ON && ack_hit) cs_on_q <= 1'b1;
            if (state_q == CS_OFF && ack_hit) cs_on_q <= 1'b0;
            if (state_q == READ_RX && ack_hit) rsp_data_q <= acc_rdata;
            if (timeout_hit) error_q <= 1'b1;
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign error     = error_q;

    sbus_access #(
        .ACK_TIMEOUT(ACK_TIMEOUT)
    ) u_access (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (acc_start),
        .rw         (acc_rw),
        .addr       (acc_addr),
        .wdata      (acc_wdata),
        .sb         (sb),
        .busy       (acc_busy),
        .ack_hit    (ack_hit),
        .timeout_hit(timeout_hit),
        .rdata      (acc_rdata)
    );

endmodule

// File: tb/tb_sbus_spi_sequencer.sv
// Randomised bench: a transaction-level model predicts every bus access and
// response byte; a monitor compares the DUT against it each cycle.
module tb_sbus_spi_sequencer;
    import sbus_spi_pkg::*;

    typedef struct packed {
        logic [7:0] addr;
        logic       rw;
        logic [7:0] wdata;
    } txn_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_valid;
    logic       req_ready;
    logic [7:0] req_data;
    logic       req_last;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       error;

    sbus_spi_sequencer_if sb_if ();

    sbus_spi_sequencer dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_data (req_data),
        .req_last (req_last),
        .rsp_valid(rsp_valid),
        .rsp_data (rsp_data),
        .error    (error),
        .sb       (sb_if)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    txn_t       exp_q[$];
    logic [7:0] exp_rsp[$];
    logic [7:0] sr_q[$];
    logic [7:0] rx_q[$];
    bit         cs_low = 1'b0;

    int  ack_dly    = 3;
    bit  never_ack  = 1'b0;
    bit  bus_manual = 1'b0;

    int  csr_writes   = 0;
    int  rsp_cnt      = 0;
    int  sr_run       = 0;
    int  sr_before_tx = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    function automatic txn_t mk(input logic [7:0] a, input logic rw, input logic [7:0] wd);
        txn_t t;
        t.addr  = a;
        t.rw    = rw;
        t.wdata = wd;
        return t;
    endfunction

    task automatic plan_cfg();
        exp_q.push_back(mk(8'h09, 1'b1, 8'h80));
        exp_q.push_back(mk(8'h0B, 1'b1, 8'h05));
        exp_q.push_back(mk(8'h0A, 1'b1, 8'hC0));
        exp_q.push_back(mk(8'h0F, 1'b1, 8'h0F));
    endtask

    // Predicts the bus traffic of one byte exchange and queues the status/RX data
    // the bus model will return for it.
    task automatic plan_req(input logic [7:0] d, input bit last, input int ntx, input int nrx,
                            input logic [7:0] rx, input logic [7:0] tx_rdy,
                            input logic [7:0] rx_rdy, input bit zero_nr);
        if (!cs_low) begin
            exp_q.push_back(mk(SPICSR, 1'b1, 8'h0E));
            cs_low = 1'b1;
        end
        for (int i = 0; i < ntx; i++) begin
            sr_q.push_back(zero_nr ? 8'h00 : (8'($urandom) & 8'hEF));
            exp_q.push_back(mk(SPISR, 1'b0, 8'h00));
        end
        sr_q.push_back(tx_rdy);
        exp_q.push_back(mk(SPISR, 1'b0, 8'h00));
        exp_q.push_back(mk(SPITXDR, 1'b1, d));
        for (int i = 0; i < nrx; i++) begin
            sr_q.push_back(zero_nr ? 8'h00 : (8'($urandom) & 8'hF7));
            exp_q.push_back(mk(SPISR, 1'b0, 8'h00));
        end
        sr_q.push_back(rx_rdy);
        exp_q.push_back(mk(SPISR, 1'b0, 8'h00));
        exp_q.push_back(mk(SPIRXDR, 1'b0, 8'h00));
        rx_q.push_back(rx);
        exp_rsp.push_back(rx);
        if (last) begin
            exp_q.push_back(mk(SPICSR, 1'b1, 8'h0F));
            cs_low = 1'b0;
        end
    endtask

    task automatic send_req(input logic [7:0] d, input bit last);
        req_data  = d;
        req_last  = last;
        req_valid = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if (req_ready) break;
            @(negedge clk);
        end
        if (!req_ready) chk("req_accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_idle(input string name);
        bit done = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            if (exp_q.size() == 0 && exp_rsp.size() == 0 && req_ready) begin
                done = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk(name, {31'd0, done}, 32'd1);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_stb"}, {31'd0, sb_if.stb}, 32'd0);
        chk({tag, "_rw"}, {31'd0, sb_if.rw}, 32'd0);
        chk({tag, "_addr"}, {24'd0, sb_if.addr}, 32'd0);
        chk({tag, "_wdata"}, {24'd0, sb_if.wdata}, 32'd0);
        chk({tag, "_req_ready"}, {31'd0, req_ready}, 32'd0);
        chk({tag, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
        chk({tag, "_rsp_data"}, {24'd0, rsp_data}, 32'd0);
        chk({tag, "_error"}, {31'd0, error}, 32'd0);
    endtask

    task automatic clear_model();
        exp_q.delete();
        exp_rsp.delete();
        sr_q.delete();
        rx_q.delete();
        cs_low = 1'b0;
    endtask

    // Bus slave: acks in the ack_dly-th strobe-high cycle.
    initial begin
        int bcnt = 0;
        sb_if.ack   = 1'b0;
        sb_if.rdata = 8'h00;
        forever begin
            @(negedge clk);
            if (bus_manual) begin
                bcnt = 0;
            end else begin
                sb_if.ack = 1'b0;
                if (sb_if.stb) begin
                    bcnt++;
                    if (!never_ack && bcnt == ack_dly) begin
                        sb_if.ack = 1'b1;
                        if (sb_if.addr == SPISR && !sb_if.rw)
                            sb_if.rdata = (sr_q.size() != 0) ? sr_q.pop_front() : 8'h18;
                        else if (sb_if.addr == SPIRXDR && !sb_if.rw)
                            sb_if.rdata = (rx_q.size() != 0) ? rx_q.pop_front() : 8'h00;
                        else
                            sb_if.rdata = 8'h00;
                    end
                end else begin
                    bcnt = 0;
                end
            end
        end
    end

    // Monitor: compares every completed access and every response with the model.
    initial begin
        logic       prev_stb = 1'b0, prev_ack = 1'b0, prev_rw = 1'b0;
        logic [7:0] prev_addr = 8'h00;
        logic [16:0] rise_val = '0;
        txn_t t;
        forever begin
            @(negedge clk);
            #1;
            if (sb_if.stb && !prev_stb) rise_val = {sb_if.addr, sb_if.rw, sb_if.wdata};
            if (rst_n) begin
                if (prev_stb && prev_ack) chk("stb_fall_after_ack", {31'd0, sb_if.stb}, 32'd0);
                if (prev_stb && prev_ack && prev_addr == SPIRXDR && !prev_rw)
                    chk("rsp_latency", {31'd0, rsp_valid}, 32'd1);
                if (sb_if.stb && sb_if.ack) begin
                    chk("stb_stable", {15'd0, sb_if.addr, sb_if.rw, sb_if.wdata},
                        {15'd0, rise_val});
                    if (exp_q.size() == 0) begin
                        chk("bus_unexpected", {24'd0, sb_if.addr}, 32'hFFFF);
                    end else begin
                        t = exp_q.pop_front();
                        chk("bus_addr", {24'd0, sb_if.addr}, {24'd0, t.addr});
                        chk("bus_rw", {31'd0, sb_if.rw}, {31'd0, t.rw});
                        if (t.rw) chk("bus_wdata", {24'd0, sb_if.wdata}, {24'd0, t.wdata});
                    end
                    if (sb_if.rw && sb_if.addr == SPICSR) csr_writes++;
                    if (!sb_if.rw && sb_if.addr == SPISR) begin
                        sr_run++;
                    end else begin
                        if (sb_if.rw && sb_if.addr == SPITXDR) sr_before_tx = sr_run;
                        sr_run = 0;
                    end
                end
                if (rsp_valid) begin
                    rsp_cnt++;
                    chk("ready_low_in_rsp", {31'd0, req_ready}, 32'd0);
                    if (exp_rsp.size() == 0) chk("rsp_unexpected", {24'd0, rsp_data}, 32'hFFFF);
                    else chk("rsp_data", {24'd0, rsp_data}, {24'd0, exp_rsp.pop_front()});
                end
            end
            prev_stb  = sb_if.stb;
            prev_ack  = sb_if.ack;
            prev_addr = sb_if.addr;
            prev_rw   = sb_if.rw;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1);
    end

    initial begin
        int c0, r0, hi;
        bit ok;
        logic [7:0] d;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_data  = 8'h00;
        req_last  = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_values("reset");

        // Configuration writes after reset.
        plan_cfg();
        rst_n = 1'b1;
        wait_idle("cfg_done");
        chk("cfg_ready", {31'd0, req_ready}, 32'd1);

        // Single framed byte with literal status/RX data.
        c0 = csr_writes;
        plan_req(8'hA5, 1'b1, 0, 0, 8'h3C, 8'h18, 8'h18, 1'b0);
        send_req(8'hA5, 1'b1);
        wait_idle("single_done");
        chk("single_cs_writes", c0 - csr_writes + 2 * (csr_writes - c0), 32'd2);

        // Two bytes in one frame, second presented during the first response.
        c0 = csr_writes;
        r0 = rsp_cnt;
        plan_req(8'h11, 1'b0, 0, 0, 8'($urandom), 8'h18, 8'h18, 1'b0);
        plan_req(8'h22, 1'b1, 0, 0, 8'($urandom), 8'h18, 8'h18, 1'b0);
        send_req(8'h11, 1'b0);
        for (int i = 0; i < 2000; i++) begin
            if (rsp_valid) break;
            @(negedge clk);
        end
        send_req(8'h22, 1'b1);
        wait_idle("b2b_done");
        chk("b2b_cs_writes", csr_writes - c0, 32'd2);
        chk("b2b_rsp_pulses", rsp_cnt - r0, 32'd2);

        // TX not ready three times before TRDY.
        plan_req(8'h7E, 1'b1, 3, 0, 8'hC3, 8'h10, 8'h18, 1'b1);
        send_req(8'h7E, 1'b1);
        wait_idle("poll_done");
        chk("sr_reads_before_tx", sr_before_tx, 32'd4);
        chk("poll_no_error", {31'd0, error}, 32'd0);

        // Randomised traffic.
        for (int k = 0; k < 20; k++) begin
            ack_dly = $urandom_range(1, 4);
            d = 8'($urandom);
            ok = 1'($urandom_range(0, 1));
            plan_req(d, ok, $urandom_range(0, 3), $urandom_range(0, 3), 8'($urandom),
                     8'($urandom) | 8'h10, 8'($urandom) | 8'h08, 1'b0);
            send_req(d, ok);
            if ($urandom_range(0, 1) == 1) wait_idle("rand_idle");
        end
        wait_idle("rand_done");
        ack_dly = 3;

        // Bus never acknowledges.
        never_ack = 1'b1;
        send_req(8'h99, 1'b1);
        for (int i = 0; i < 100; i++) begin
            if (sb_if.stb) break;
            @(negedge clk);
        end
        hi = 0;
        for (int i = 0; i < 400; i++) begin
            if (!sb_if.stb) break;
            hi++;
            @(negedge clk);
        end
        chk("timeout_stb_cycles", hi, 32'd255);
        chk("timeout_error", {31'd0, error}, 32'd1);
        ok = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (req_ready || sb_if.stb || rsp_valid) ok = 1'b0;
        end
        chk("error_hold", {31'd0, ok}, 32'd1);
        chk("error_sticky", {31'd0, error}, 32'd1);
        clear_model();
        never_ack = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_values("err_reset");
        plan_cfg();
        rst_n = 1'b1;
        wait_idle("cfg_after_error");

        // Reset while the TX data write is outstanding, followed by a late ack.
        plan_req(8'h5A, 1'b1, 0, 0, 8'h42, 8'h18, 8'h18, 1'b0);
        send_req(8'h5A, 1'b1);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (sb_if.stb && sb_if.addr == SPITXDR) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("reached_write_tx", {31'd0, ok}, 32'd1);
        bus_manual = 1'b1;
        sb_if.ack  = 1'b0;
        rst_n      = 1'b0;
        @(negedge clk);
        check_reset_values("mid_reset");
        clear_model();
        plan_cfg();
        sb_if.ack   = 1'b1;
        sb_if.rdata = 8'hFF;
        rst_n       = 1'b1;
        @(negedge clk);
        sb_if.ack  = 1'b0;
        bus_manual = 1'b0;
        chk("late_ack_no_error", {31'd0, error}, 32'd0);
        wait_idle("cfg_after_mid_reset");

        chk("final_queues_empty", exp_q.size() + exp_rsp.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
